// File: rtl/serial_subtractor_4bit.sv
// serial_subtractor_4bit
//
// Bit-serial unsigned subtractor: computes Diff = (A - B - Bin) mod 2^WIDTH
// and Bout = (A < B + Bin), one bit per clock, LSB first.
// Each operation takes WIDTH SHIFT cycles followed by a single DONE cycle.
//
// Ports
//   clk   in   1      rising-edge clock
//   rst   in   1      asynchronous active-high reset
//   start in   1      begin a subtraction (honoured only in IDLE)
//   A     in   WIDTH  minuend, captured on an accepted start
//   B     in   WIDTH  subtrahend, captured on an accepted start
//   Bin   in   1      borrow-in, captured on an accepted start
//   busy  out  1      high while bits are being processed
//   done  out  1      one-cycle pulse when Diff/Bout are updated
//   Diff  out  WIDTH  registered difference
//   Bout  out  1      registered borrow-out
module serial_subtractor_4bit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic             br_q;
  logic [CNT_W-1:0] cnt_q;

  logic             d_d;
  logic             br_d;
  logic [WIDTH-1:0] res_d;

  function automatic logic diff_bit(input logic a, input logic b, input logic br);
    return a ^ b ^ br;
  endfunction

  function automatic logic borrow_bit(input logic a, input logic b, input logic br);
    return (~a & b) | (~(a ^ b) & br);
  endfunction

  // Full-subtractor stage on the current LSBs; the new difference bit
  // enters at the MSB so that after WIDTH shifts bit 0 sits at res[0].
  always_comb begin
    d_d   = diff_bit(a_q[0], b_q[0], br_q);
    br_d  = borrow_bit(a_q[0], b_q[0], br_q);
    res_d = {d_d, res_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      Diff    <= '0;
      Bout    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_q     <= A;
            b_q     <= B;
            br_q    <= Bin;
            res_q   <= '0;
            cnt_q   <= '0;
            busy    <= 1'b1;
            state_q <= SHIFT;
          end
        end

        SHIFT: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          br_q  <= br_d;
          res_q <= res_d;
          cnt_q <= cnt_q + 1'b1;
          // Outputs are loaded only here, so partial results never escape.
          if (cnt_q == LAST_BIT) begin
            Diff    <= res_d;
            Bout    <= br_d;
            busy    <= 1'b0;
            done    <= 1'b1;
            state_q <= DONE;
          end
        end

        DONE: begin
          done    <= 1'b0;
          state_q <= IDLE;
        end

        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor_4bit.sv
module tb_serial_subtractor_4bit;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Bin;
  logic         busy;
  logic         done;
  logic [W-1:0] Diff;
  logic         Bout;

  serial_subtractor_4bit #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .A    (A),
    .B    (B),
    .Bin  (Bin),
    .busy (busy),
    .done (done),
    .Diff (Diff),
    .Bout (Bout)
  );

  always #5 clk = ~clk;

  int         n_chk = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         n_done = 0;
  int         op_done_cyc = 0;
  logic [W:0] sb_q[$];
  logic [W:0] held = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: plain (W+1)-bit subtraction; the top bit is the borrow.
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic bin);
    logic [W:0] t;
    t = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
    return t;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Scoreboard monitor: compares on done, otherwise requires outputs to hold.
  initial forever begin
    logic [W:0] exp;
    @(negedge clk);
    if (rst) begin
      held = '0;
    end else if (done) begin
      n_done++;
      if (sb_q.size() == 0) begin
        chk("done_unexpected", {31'd0, done}, 32'd0);
      end else begin
        exp = sb_q.pop_front();
        chk("result", {27'd0, Bout, Diff}, {27'd0, exp});
      end
      held = {Bout, Diff};
    end else begin
      chk("hold", {27'd0, Bout, Diff}, {27'd0, held});
    end
  end

  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    int lat;
    @(negedge clk);
    start = 1'b1;
    A     = a;
    B     = b;
    Bin   = bin;
    sb_q.push_back(model(a, b, bin));
    @(negedge clk);
    start = 1'b0;
    // Scramble operands after capture; they must not affect the result.
    A     = W'($urandom);
    B     = W'($urandom);
    Bin   = 1'($urandom);
    chk("busy_shift", {31'd0, busy}, 32'd1);
    lat = 0;
    while (!done && lat < 3 * W) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, W);
    chk("busy_done", {31'd0, busy}, 32'd0);
    op_done_cyc = cyc;
  endtask

  initial begin
    int prev;
    int d0;
    rst   = 1'b1;
    start = 1'b0;
    A     = '0;
    B     = '0;
    Bin   = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_diff", {28'd0, Diff}, 32'd0);
    chk("rst_bout", {31'd0, Bout}, 32'd0);
    rst = 1'b0;

    // Directed vectors, each followed by a one-cycle done check.
    op(4'b0011, 4'b0010, 1'b0);
    @(negedge clk); chk("done_pulse", {31'd0, done}, 32'd0);
    chk("d_0011_0010", {27'd0, Bout, Diff}, {27'd0, 5'b0_0001});
    op(4'b0010, 4'b0011, 1'b0);
    @(negedge clk); chk("d_0010_0011", {27'd0, Bout, Diff}, {27'd0, 5'b1_1111});
    op(4'b0000, 4'b0000, 1'b1);
    @(negedge clk); chk("d_0000_0000_1", {27'd0, Bout, Diff}, {27'd0, 5'b1_1111});
    op(4'b1010, 4'b0101, 1'b1);
    @(negedge clk); chk("d_1010_0101_1", {27'd0, Bout, Diff}, {27'd0, 5'b0_0100});
    op(4'b1111, 4'b1111, 1'b0);
    @(negedge clk); chk("d_1111_1111", {27'd0, Bout, Diff}, {27'd0, 5'b0_0000});

    // start held during SHIFT and DONE must be ignored.
    d0 = n_done;
    @(negedge clk);
    start = 1'b1; A = 4'b1001; B = 4'b0110; Bin = 1'b1;
    sb_q.push_back(model(4'b1001, 4'b0110, 1'b1));
    for (int k = 1; k <= W + 1; k++) begin
      @(negedge clk);
      start = 1'b1; A = 4'b0000; B = 4'b0001; Bin = 1'b0;
      chk("prot_done_timing", {31'd0, done}, (k == W + 1) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("prot_single_done", n_done - d0, 1);
    chk("prot_busy", {31'd0, busy}, 32'd0);
    chk("prot_result", {27'd0, Bout, Diff}, {27'd0, 5'b0_0010});

    // Reset in the middle of SHIFT aborts without a done pulse.
    d0 = n_done;
    @(negedge clk);
    start = 1'b1; A = 4'b0001; B = 4'b0010; Bin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_diff", {28'd0, Diff}, 32'd0);
    chk("abort_bout", {31'd0, Bout}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("abort_no_done", n_done - d0, 0);
    op(4'b0101, 4'b0001, 1'b0);
    @(negedge clk); chk("post_rst", {27'd0, Bout, Diff}, {27'd0, 5'b0_0100});

    // Exhaustive, back-to-back: start re-issued the cycle after each done.
    prev = 0;
    for (int i = 0; i < 512; i++) begin
      op(W'(i >> 5), W'(i >> 1), 1'(i));
      if (i > 0) chk("spacing", op_done_cyc - prev, W + 2);
      prev = op_done_cyc;
    end

    repeat (3) @(negedge clk);
    chk("sb_drained", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit, got %0d compares, expected completion", n_chk);
    $fatal(1, "timeout");
  end

endmodule
